// File: rtl/nios2_fp_cpu_dct_packer.sv
// Data-trace packer: gathers 2-bit trace atoms into 30-bit frames and hands
// them to the OCI trace consumer through a single-entry output register.
module nios2_fp_cpu_dct_packer #(
   parameter bit FLUSH_EMPTY_EMIT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        atom_valid,
   input  logic [1:0]  atom,
   output logic        atom_ready,
   input  logic        flush,
   output logic        dct_valid,
   input  logic        dct_ready,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count
);

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   out_state_t  out_state;
   out_state_t  out_state_next;

   logic [29:0] acc;
   logic [3:0]  acc_cnt;
   logic        flush_pending;

   logic        acc_full;
   logic        accept;
   logic        emit_req;
   logic        xfer;
   logic        flush_drop;

   always_comb begin
      acc_full   = (acc_cnt == 4'd15);
      atom_ready = !acc_full && !flush_pending && !reset;
      accept     = atom_valid && atom_ready;
      emit_req   = acc_full || (flush_pending && ((acc_cnt != 4'd0) || FLUSH_EMPTY_EMIT));
      // A frame moves out only when the output register is free or being drained.
      xfer       = emit_req && (!dct_valid || dct_ready);
      flush_drop = flush_pending && (acc_cnt == 4'd0) && !FLUSH_EMPTY_EMIT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_state <= OUT_EMPTY;
      end else begin
         out_state <= out_state_next;
      end
   end

   always_comb begin
      out_state_next = out_state;
      case (out_state)
         OUT_EMPTY: if (xfer) out_state_next = OUT_FULL;
         OUT_FULL:  if (dct_ready && !xfer) out_state_next = OUT_EMPTY;
         default:   out_state_next = OUT_EMPTY;
      endcase
   end

   always_comb begin
      dct_valid = (out_state == OUT_FULL);
   end

   // xfer and accept are mutually exclusive: xfer needs a full or flushing
   // accumulator, both of which hold atom_ready low.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         acc_cnt <= '0;
      end else if (xfer) begin
         acc     <= '0;
         acc_cnt <= '0;
      end else if (accept) begin
         acc[{acc_cnt, 1'b0} +: 2] <= atom;
         acc_cnt                   <= acc_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flush_pending <= 1'b0;
      end else if (xfer || flush_drop) begin
         flush_pending <= 1'b0;
      end else if (flush) begin
         flush_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dct_buffer <= '0;
         dct_count  <= '0;
      end else if (xfer) begin
         dct_buffer <= acc;
         dct_count  <= acc_cnt;
      end
   end

endmodule

// File: tb/tb_nios2_fp_cpu_dct_packer.sv
// Self-checking bench for nios2_fp_cpu_dct_packer: directed vector table,
// hand-written corner sequences and a randomized run against a frame scoreboard.
module tb_nios2_fp_cpu_dct_packer;

   logic        clk;
   logic        reset;
   logic        atom_valid;
   logic [1:0]  atom;
   logic        atom_ready;
   logic        flush;
   logic        dct_valid;
   logic        dct_ready;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;

   logic        av1;
   logic [1:0]  a1;
   logic        ar1;
   logic        fl1;
   logic        dv1;
   logic        rdy1;
   logic [29:0] buf1;
   logic [3:0]  cnt1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [29:0] b;
      logic [3:0]  c;
   } frame_t;

   typedef struct {
      logic        av;
      logic [1:0]  a;
      logic        fl;
      logic        rdy;
      logic        e_ar;
      logic        e_dv;
      logic [29:0] e_buf;
      logic [3:0]  e_cnt;
   } vec_t;

   logic [1:0] cur[$];
   frame_t     expq[$];
   logic [1:0] bpq[$];

   nios2_fp_cpu_dct_packer #(.FLUSH_EMPTY_EMIT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom(atom),
      .atom_ready(atom_ready), .flush(flush), .dct_valid(dct_valid),
      .dct_ready(dct_ready), .dct_buffer(dct_buffer), .dct_count(dct_count)
   );

   nios2_fp_cpu_dct_packer #(.FLUSH_EMPTY_EMIT(1'b1)) dut1 (
      .clk(clk), .reset(reset), .atom_valid(av1), .atom(a1),
      .atom_ready(ar1), .flush(fl1), .dct_valid(dv1),
      .dct_ready(rdy1), .dct_buffer(buf1), .dct_count(cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Frame value is the sum of atom_k * 4**k over the atoms it holds.
   function automatic logic [29:0] pack(input logic [1:0] q[$], input int first, input int n);
      logic [29:0] b;
      b = '0;
      for (int k = 0; k < n; k++) b = b + (30'(q[first + k]) << (2 * k));
      return b;
   endfunction

   task automatic push_cur();
      frame_t f;
      f.b = pack(cur, 0, cur.size());
      f.c = 4'(cur.size());
      expq.push_back(f);
      cur.delete();
   endtask

   // Samples the settled handshakes of this cycle into the model, then advances one clock.
   task automatic tick();
      bit done;
      if (reset) begin
         cur.delete();
         expq.delete();
      end else begin
         done = 1'b0;
         if (atom_valid && atom_ready) begin
            cur.push_back(atom);
            if (cur.size() == 15) begin
               push_cur();
               done = 1'b1;
            end
         end
         if (flush && atom_ready && !done && cur.size() != 0) push_cur();
         if (dct_valid) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got frame %h/%0d required no frame", dct_buffer, dct_count);
            end else begin
               check("sb_buf", dct_buffer, expq[0].b);
               check("sb_cnt", dct_count, expq[0].c);
               if (dct_ready) void'(expq.pop_front());
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vec_t vt[25];
      int   n;
      bit   found;

      for (int i = 0; i < 15; i++) vt[i] = '{1'b1, 2'(i % 4), 1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 4'd0};
      vt[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h0,        4'd0};
      vt[16] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 30'h24E4E4E4, 4'd15};
      vt[17] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0,        4'd0};
      vt[18] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0,        4'd0};
      vt[19] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0,        4'd0};
      vt[20] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0,        4'd0};
      vt[21] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 30'h0,        4'd0};
      vt[22] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h0,        4'd0};
      vt[23] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 30'h1B,       4'd3};
      vt[24] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0,        4'd0};

      reset = 1'b1; atom_valid = 1'b0; atom = 2'd0; flush = 1'b0; dct_ready = 1'b1;
      av1 = 1'b0; a1 = 2'd0; fl1 = 1'b0; rdy1 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_valid", dct_valid, 0);
      check("rst_buf", dct_buffer, 0);
      check("rst_cnt", dct_count, 0);
      check("rst_ready", atom_ready, 0);
      check("rst_valid1", dv1, 0);
      tick();
      reset = 1'b0;

      for (int i = 0; i < 25; i++) begin
         atom_valid = vt[i].av; atom = vt[i].a; flush = vt[i].fl; dct_ready = vt[i].rdy;
         #1;
         check($sformatf("vec%0d_ready", i), atom_ready, vt[i].e_ar);
         check($sformatf("vec%0d_valid", i), dct_valid, vt[i].e_dv);
         if (vt[i].e_dv) begin
            check($sformatf("vec%0d_buf", i), dct_buffer, vt[i].e_buf);
            check($sformatf("vec%0d_cnt", i), dct_count, vt[i].e_cnt);
         end
         tick();
      end
      atom_valid = 1'b0; flush = 1'b0;

      // Empty flush: dropped with FLUSH_EMPTY_EMIT=0, zero-count frame with 1.
      flush = 1'b1; fl1 = 1'b1;
      #1;
      check("ef_ready1_a", ar1, 1);
      tick();
      flush = 1'b0; fl1 = 1'b0;
      #1;
      check("ef_ready0_b", atom_ready, 0);
      check("ef_ready1_b", ar1, 0);
      check("ef_valid1_b", dv1, 0);
      tick();
      #1;
      check("ef_valid0_c", dct_valid, 0);
      check("ef_ready0_c", atom_ready, 1);
      check("ef_valid1_c", dv1, 1);
      check("ef_cnt1_c", cnt1, 0);
      check("ef_buf1_c", buf1, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ef_valid0_idle", dct_valid, 0);
         check("ef_valid1_idle", dv1, 0);
         tick();
      end

      // Flush together with the 15th atom yields one full frame and no empty frame.
      for (int i = 0; i < 15; i++) begin
         atom_valid = 1'b1; atom = 2'($urandom_range(0, 3)); flush = (i == 14);
         tick();
      end
      atom_valid = 1'b0; flush = 1'b0;
      #1;
      check("f15_ready_xfer", atom_ready, 0);
      check("f15_valid_xfer", dct_valid, 0);
      tick();
      atom_valid = 1'b1; atom = 2'd2;
      #1;
      check("f15_valid", dct_valid, 1);
      check("f15_cnt", dct_count, 15);
      check("f15_ready_after", atom_ready, 1);
      tick();
      atom_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("f15_no_empty", dct_valid, 0);
         tick();
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (4) tick();

      // Backpressure: output held while a second frame fills the accumulator.
      n = 0;
      for (int c = 0; c < 40; c++) begin
         atom_valid = 1'b1; atom = 2'($urandom_range(0, 3)); dct_ready = 1'b0;
         #1;
         if (atom_ready) begin
            n++;
            bpq.push_back(atom);
         end
         tick();
      end
      atom_valid = 1'b0;
      check("bp_accepted", n, 30);
      dct_ready = 1'b1;
      #1;
      check("bp_f1_valid", dct_valid, 1);
      check("bp_f1_buf", dct_buffer, pack(bpq, 0, 15));
      tick();
      #1;
      check("bp_no_bubble", dct_valid, 1);
      check("bp_f2_buf", dct_buffer, pack(bpq, 15, 15));
      check("bp_f2_cnt", dct_count, 15);
      tick();
      #1;
      check("bp_drained", dct_valid, 0);
      tick();

      // Reset with a held frame and a partial accumulator discards everything.
      n = 0;
      dct_ready = 1'b0;
      for (int c = 0; c < 60 && n < 22; c++) begin
         atom_valid = 1'b1; atom = 2'($urandom_range(0, 3));
         #1;
         if (atom_ready) n++;
         tick();
      end
      atom_valid = 1'b0;
      check("mr_fill", n, 22);
      #1;
      check("mr_pre_valid", dct_valid, 1);
      reset = 1'b1;
      #1;
      check("mr_ready_in_reset", atom_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      check("mr_valid", dct_valid, 0);
      check("mr_buf", dct_buffer, 0);
      check("mr_cnt", dct_count, 0);
      check("mr_ready", atom_ready, 1);
      dct_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 15; c++) begin
         atom_valid = 1'b1; atom = 2'($urandom_range(0, 3));
         #1;
         if (atom_ready) n++;
         tick();
      end
      atom_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 5 && !found; c++) begin
         #1;
         if (dct_valid) begin
            found = 1'b1;
            check("mr_clean_cnt", dct_count, 15);
         end
         tick();
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL mr_clean_frame: got no frame required frame within 5 cycles");
      end

      // Randomized traffic against the scoreboard.
      for (int c = 0; c < 3000; c++) begin
         atom_valid = ($urandom_range(0, 3) != 0);
         atom       = 2'($urandom_range(0, 3));
         dct_ready  = ($urandom_range(0, 9) < 7);
         flush      = atom_ready && ($urandom_range(0, 19) == 0);
         tick();
      end

      atom_valid = 1'b0; dct_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         flush = atom_ready && (cur.size() != 0);
         #1;
         if (expq.size() == 0 && cur.size() == 0 && !dct_valid) found = 1'b1;
         tick();
      end
      flush = 1'b0;
      check("drain_empty", 32'(expq.size() + cur.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
